// File: rtl/credit_flit_sender.sv
// credit_flit_sender: credit-based flit transmitter feeding an NI receive FIFO
// over a link with no ready. Never sends a flit without a credit, tracks
// HEAD/BODY/TAIL packet framing and raises a sticky protocol-error flag.
// Optional feature macro: CREDIT_SENDER_PKT_CNT_EN enables the 16-bit packet
// counter on pkt_cnt_o; without it pkt_cnt_o is tied to zero.

`ifndef DW
`define DW 34
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef BODY
`define BODY 2'b00
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif

module credit_flit_sender #(
    parameter int unsigned CREDIT_MAX = 4,
    parameter int unsigned CW         = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [`DW-1:0]   data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [`DW-1:0]   data_o,
    input  logic             credit_upd_i,
    output logic [CW-1:0]    credit_o,
    output logic             proto_err_o,
    output logic [15:0]      pkt_cnt_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         accept;
    logic [1:0]   flit_type;
    logic         framing_err;
    logic         tail_done;
    logic         credit_overflow;
    logic [CW-1:0] credit;

    assign flit_type = data_i[`DW-1:`DW-2];
    assign ready_o   = (credit != '0);
    assign accept    = valid_i & ready_o;
    assign credit_o  = credit;

    // A credit return with no pending debit while already full is a protocol error.
    assign credit_overflow = ~accept & credit_upd_i & (credit == CW'(CREDIT_MAX));

    // Output register: launch one flit per accept, hold data otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= accept;
            if (accept) begin
                data_o <= data_i;
            end
        end
    end

    // Credit counter: debit on accept, credit on return, saturate at the maximum.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit <= CW'(CREDIT_MAX);
        end else if (accept && !credit_upd_i) begin
            credit <= credit - CW'(1);
        end else if (!accept && credit_upd_i && !credit_overflow) begin
            credit <= credit + CW'(1);
        end
    end

    // Framing state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Framing next-state: advance on accepted flits; bad flits leave the state unchanged.
    always_comb begin
        state_next  = state;
        framing_err = 1'b0;
        tail_done   = 1'b0;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (flit_type == `HEAD) begin
                        state_next = IN_PKT;
                    end else begin
                        framing_err = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (flit_type == `TAIL) begin
                        state_next = IDLE;
                        tail_done  = 1'b1;
                    end else if (flit_type != `BODY) begin
                        framing_err = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Sticky protocol-error flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            proto_err_o <= 1'b0;
        end else if (framing_err || credit_overflow) begin
            proto_err_o <= 1'b1;
        end
    end

`ifdef CREDIT_SENDER_PKT_CNT_EN
    logic [15:0] pkt_cnt;

    // Packet counter: one per TAIL closing a packet, wrapping at 16 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_cnt <= '0;
        end else if (tail_done) begin
            pkt_cnt <= pkt_cnt + 16'd1;
        end
    end

    assign pkt_cnt_o = pkt_cnt;
`else
    logic unused_tail_done;

    assign unused_tail_done = tail_done;
    assign pkt_cnt_o        = '0;
`endif

endmodule
